// File: rtl/fir_tdm_sequencer.sv
// Time-division sequencer: feeds NCH channel samples into a shared interleaved FIR core in strict channel
// order and returns the core's results tagged and scaled. Define FIR_SAT_EN to saturate out-of-range results.
module fir_tdm_sequencer #(
    parameter int unsigned NCH   = 4,
    parameter int unsigned DW    = 16,
    parameter int unsigned ODW   = 40,
    parameter int unsigned SHIFT = 15
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic [NCH-1:0]         ch_valid,
    input  logic [NCH*DW-1:0]      ch_data,
    output logic [NCH-1:0]         ch_ready,
    output logic                   f_s_tvalid,
    input  logic                   f_s_tready,
    output logic [DW-1:0]          f_s_tdata,
    input  logic                   f_m_tvalid,
    input  logic [ODW-1:0]         f_m_tdata,
    output logic                   out_valid,
    output logic [$clog2(NCH)-1:0] out_ch,
    output logic [DW-1:0]          out_data,
    output logic                   frame_done,
    output logic                   seq_err
);
    localparam int unsigned CHW = $clog2(NCH);
    localparam int unsigned IFW = $clog2(NCH * 8) + 1;
    localparam int unsigned TBW = ODW - SHIFT - DW + 1;
    localparam logic [CHW-1:0] LAST_CH = CHW'(NCH - 1);
    localparam logic [IFW-1:0] IF_MAX  = '1;

    typedef enum logic {ST_SEL = 1'b0, ST_XFER = 1'b1} state_e;

    state_e                 state_q, state_d;
    logic [CHW-1:0]         ip_q, ip_d;
    logic [NCH-1:0]         full_q, full_d;
    logic [NCH-1:0][DW-1:0] hold_q;
    logic [NCH-1:0]         load;
    logic [DW-1:0]          s_data_q, s_data_d;
    logic [IFW-1:0]         infl_q, infl_d;
    logic [CHW-1:0]         rp_q;
    logic                   out_valid_q, frame_done_q, seq_err_q;
    logic [CHW-1:0]         out_ch_q;
    logic [DW-1:0]          out_data_q;
    logic [DW-1:0]          scaled;
    logic                   issue, advance, s_hs;

    assign load       = ch_valid & ~full_q;
    assign ch_ready   = ~full_q;
    assign f_s_tvalid = (state_q == ST_XFER);
    assign f_s_tdata  = s_data_q;
    assign s_hs       = f_s_tvalid & f_s_tready;
    assign out_valid  = out_valid_q;
    assign out_ch     = out_ch_q;
    assign out_data   = out_data_q;
    assign frame_done = frame_done_q;
    assign seq_err    = seq_err_q;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) state_q <= ST_SEL;
        else        state_q <= state_d;
    end

    always_comb begin : next_state
        state_d = state_q;
        unique case (state_q)
            ST_SEL:  if (full_q[ip_q]) state_d = ST_XFER;
            ST_XFER: if (f_s_tready)   state_d = ST_SEL;
            default: state_d = ST_SEL;
        endcase
    end

    always_comb begin : fsm_out
        issue   = 1'b0;
        advance = 1'b0;
        unique case (state_q)
            ST_SEL:  issue   = full_q[ip_q];
            ST_XFER: advance = f_s_tready;
            default: ;
        endcase
    end

    // Issue datapath: drain the pointed-to holding reg, then step the pointer once the core accepts
    always_comb begin
        full_d   = full_q | load;
        s_data_d = s_data_q;
        ip_d     = ip_q;
        if (issue) begin
            full_d[ip_q] = 1'b0;
            s_data_d     = hold_q[ip_q];
        end
        if (advance) ip_d = (ip_q == LAST_CH) ? '0 : ip_q + CHW'(1);
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            full_q   <= '0;
            hold_q   <= '0;
            s_data_q <= '0;
            ip_q     <= '0;
        end else begin
            full_q   <= full_d;
            s_data_q <= s_data_d;
            ip_q     <= ip_d;
            for (int k = 0; k < NCH; k++)
                if (load[k]) hold_q[k] <= ch_data[k*DW +: DW];
        end
    end

    // Samples inside the core; simultaneous issue and return cancel out
    always_comb begin
        infl_d = infl_q;
        if (s_hs && !f_m_tvalid && infl_q != IF_MAX)
            infl_d = infl_q + IFW'(1);
        else if (!s_hs && f_m_tvalid && infl_q != '0)
            infl_d = infl_q - IFW'(1);
    end

`ifdef FIR_SAT_EN
    logic [TBW-1:0] top_bits;
    logic           unused_bits;
    assign top_bits    = f_m_tdata[ODW-1:SHIFT+DW-1];
    assign unused_bits = ^f_m_tdata[SHIFT-1:0];

    always_comb begin
        scaled = f_m_tdata[SHIFT +: DW];
        if (!(&top_bits) && (|top_bits))
            scaled = f_m_tdata[ODW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end
`else
    logic unused_bits;
    assign unused_bits = ^{f_m_tdata[ODW-1:SHIFT+DW], f_m_tdata[SHIFT-1:0], TBW'(0)};
    assign scaled      = f_m_tdata[SHIFT +: DW];
`endif

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            infl_q       <= '0;
            rp_q         <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            out_ch_q     <= '0;
            out_data_q   <= '0;
            seq_err_q    <= 1'b0;
        end else begin
            infl_q       <= infl_d;
            out_valid_q  <= f_m_tvalid;
            frame_done_q <= f_m_tvalid && (rp_q == LAST_CH);
            if (f_m_tvalid) begin
                out_ch_q   <= rp_q;
                out_data_q <= scaled;
                rp_q       <= (rp_q == LAST_CH) ? '0 : rp_q + CHW'(1);
                if (infl_q == '0) seq_err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fir_tdm_sequencer.sv
// Bench for fir_tdm_sequencer: directed corner sequences, a result table, and randomized traffic
// against a queue-based channel-order / result-tagging model.
module tb_fir_tdm_sequencer;
    localparam int unsigned NCH   = 4;
    localparam int unsigned DW    = 16;
    localparam int unsigned ODW   = 40;
    localparam int unsigned SHIFT = 15;

    logic              aclk = 1'b0;
    logic              areset = 1'b1;
    logic [NCH-1:0]    ch_valid = '0;
    logic [NCH*DW-1:0] ch_data = '0;
    logic [NCH-1:0]    ch_ready;
    logic              f_s_tvalid;
    logic              f_s_tready = 1'b0;
    logic [DW-1:0]     f_s_tdata;
    logic              f_m_tvalid = 1'b0;
    logic [ODW-1:0]    f_m_tdata = '0;
    logic              out_valid;
    logic [1:0]        out_ch;
    logic [DW-1:0]     out_data;
    logic              frame_done;
    logic              seq_err;

    fir_tdm_sequencer #(.NCH(NCH), .DW(DW), .ODW(ODW), .SHIFT(SHIFT)) dut (
        .aclk(aclk), .areset(areset),
        .ch_valid(ch_valid), .ch_data(ch_data), .ch_ready(ch_ready),
        .f_s_tvalid(f_s_tvalid), .f_s_tready(f_s_tready), .f_s_tdata(f_s_tdata),
        .f_m_tvalid(f_m_tvalid), .f_m_tdata(f_m_tdata),
        .out_valid(out_valid), .out_ch(out_ch), .out_data(out_data),
        .frame_done(frame_done), .seq_err(seq_err)
    );

    always #5 aclk = ~aclk;

    int unsigned n_chk = 0;
    int unsigned n_pass = 0;

    // Model state: per-channel queues of accepted samples, expected issue channel, results owed
    logic [DW-1:0] chq [NCH][$];
    logic [18:0]   expq [$];
    int unsigned   exp_ch = 0;
    int unsigned   hs_cnt = 0;
    int            model_infl = 0;
    int unsigned   ret_cnt = 0;
    logic          ret_mon_en = 1'b0;

    typedef struct {
        logic [ODW-1:0] tdata;
        logic [1:0]     ch;
        logic [DW-1:0]  data;
        logic           fd;
    } ret_vec_t;
    ret_vec_t tbl [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [DW-1:0] ref_scale(input logic [ODW-1:0] d);
        longint v;
        v = longint'($signed(d)) >>> SHIFT;
`ifdef FIR_SAT_EN
        if (v > 32767)  return 16'h7FFF;
        if (v < -32768) return 16'h8000;
`endif
        return v[15:0];
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic clear_model();
        for (int k = 0; k < NCH; k++) chq[k].delete();
        expq.delete();
        exp_ch = 0; hs_cnt = 0; model_infl = 0; ret_cnt = 0;
    endtask

    task automatic do_reset();
        areset = 1'b1; ch_valid = '0; f_s_tready = 1'b0; f_m_tvalid = 1'b0; f_m_tdata = '0;
        tick(); tick();
        areset = 1'b0;
        clear_model();
        tick();
    endtask

    task automatic put(input logic [NCH-1:0] m, input logic [DW-1:0] d);
        ch_valid = m;
        for (int k = 0; k < NCH; k++) if (m[k]) ch_data[k*DW +: DW] = d ^ DW'(k * 16'h1111);
        tick();
        ch_valid = '0;
    endtask

    task automatic drive_ret(input logic [ODW-1:0] d);
        logic [1:0] c;
        c = 2'(ret_cnt % NCH);
        f_m_tvalid = 1'b1;
        f_m_tdata  = d;
        model_infl--;
        expq.push_back({c, ref_scale(d), c == 2'(NCH - 1)});
        ret_cnt++;
    endtask

    // Sample accept / core issue / result return, observed mid-cycle
    always @(negedge aclk) begin
        if (!areset) begin
            for (int k = 0; k < NCH; k++)
                if (ch_valid[k] && ch_ready[k]) chq[k].push_back(ch_data[k*DW +: DW]);
            if (f_s_tvalid && f_s_tready) begin
                hs_cnt++;
                model_infl++;
                if (chq[exp_ch].size() == 0) begin
                    n_chk++;
                    $display("FAIL issue_order: sample 0x%0h issued, required channel %0d has none", f_s_tdata, exp_ch);
                end else chk("issue_order", 64'(f_s_tdata), 64'(chq[exp_ch].pop_front()));
                exp_ch = (exp_ch + 1) % NCH;
            end
            if (ret_mon_en && out_valid) begin
                if (expq.size() == 0) begin
                    n_chk++;
                    $display("FAIL ret_extra: unexpected result ch %0d data 0x%0h", out_ch, out_data);
                end else chk("ret_result", 64'({out_ch, out_data, frame_done}), 64'(expq.pop_front()));
            end
        end
    end

    initial begin
        tbl[0] = '{40'h00_0004_0000, 2'd0, 16'h0008, 1'b0};
`ifdef FIR_SAT_EN
        tbl[1] = '{40'h00_8000_0000, 2'd1, 16'h7FFF, 1'b0};
        tbl[3] = '{40'hFF_0000_0000, 2'd3, 16'h8000, 1'b1};
        tbl[5] = '{40'h00_4000_0000, 2'd1, 16'h7FFF, 1'b0};
        tbl[7] = '{40'h12_3456_789A, 2'd3, 16'h7FFF, 1'b1};
`else
        tbl[1] = '{40'h00_8000_0000, 2'd1, 16'h0000, 1'b0};
        tbl[3] = '{40'hFF_0000_0000, 2'd3, 16'h0000, 1'b1};
        tbl[5] = '{40'h00_4000_0000, 2'd1, 16'h8000, 1'b0};
        tbl[7] = '{40'h12_3456_789A, 2'd3, 16'h68AC, 1'b1};
`endif
        tbl[2] = '{40'hFF_FFFF_8000, 2'd2, 16'hFFFF, 1'b0};
        tbl[4] = '{40'h00_3FFF_8000, 2'd0, 16'h7FFF, 1'b0};
        tbl[6] = '{40'hFF_C000_0000, 2'd2, 16'h8000, 1'b0};

        do_reset();
        chk("rst_ch_ready", 64'(ch_ready), 64'hF);
        chk("rst_tvalid", 64'(f_s_tvalid), 64'h0);
        chk("rst_tdata", 64'(f_s_tdata), 64'h0);
        chk("rst_out", 64'({out_valid, frame_done, seq_err, out_ch, out_data}), 64'h0);

        // Reset mid-XFER with ip=1 and rp=1
        f_s_tready = 1'b1;
        put(4'b0001, 16'h1111);
        tick(); tick();
        f_s_tready = 1'b0;
        put(4'b0010, 16'h2222);
        f_m_tvalid = 1'b1; f_m_tdata = 40'h00_0004_0000;
        tick();
        f_m_tvalid = 1'b0;
        chk("pre_rst_tvalid", 64'(f_s_tvalid), 64'h1);
        chk("pre_rst_out_valid", 64'(out_valid), 64'h1);
        areset = 1'b1;
        #1;
        chk("async_rst_tvalid", 64'(f_s_tvalid), 64'h0);
        chk("async_rst_ch_ready", 64'(ch_ready), 64'hF);
        chk("async_rst_out_valid", 64'(out_valid), 64'h0);
        tick();
        areset = 1'b0;
        clear_model();
        tick();
        f_m_tvalid = 1'b1; f_m_tdata = 40'h00_0004_0000;
        tick();
        f_m_tvalid = 1'b0;
        chk("rp_after_rst", 64'(out_ch), 64'h0);
        chk("seq_err_empty", 64'(seq_err), 64'h1);

        // Out-of-order arrival, in-order issue
        do_reset();
        f_s_tready = 1'b1;
        put(4'b1000, 16'hA003);
        put(4'b0010, 16'hA001);
        put(4'b0001, 16'hA000);
        put(4'b0100, 16'hA002);
        repeat (12) tick();
        chk("order_count", 64'(hs_cnt), 64'd4);
        chk("order_ready", 64'(ch_ready), 64'hF);

        // Channel 1 stalls the rotation
        do_reset();
        f_s_tready = 1'b1;
        put(4'b1101, 16'hB000);
        repeat (20) tick();
        chk("stall_count", 64'(hs_cnt), 64'd1);
        chk("stall_ready", 64'(ch_ready), 64'h3);
        chk("stall_tvalid", 64'(f_s_tvalid), 64'h0);
        put(4'b0010, 16'hB111);
        repeat (10) tick();
        chk("stall_release_count", 64'(hs_cnt), 64'd4);
        chk("stall_release_ready", 64'(ch_ready), 64'hF);

        // Core backpressure holds the beat
        do_reset();
        put(4'b0001, 16'h0A0A);
        put(4'b0010, 16'h0B0B);
        for (int i = 0; i < 5; i++) begin
            chk("bp_tvalid", 64'(f_s_tvalid), 64'h1);
            chk("bp_tdata", 64'(f_s_tdata), 64'h0A0A);
            tick();
        end
        chk("bp_no_issue", 64'(hs_cnt), 64'd0);
        f_s_tready = 1'b1;
        repeat (6) tick();
        chk("bp_release_count", 64'(hs_cnt), 64'd2);

        // Return tagging and scaling table (core results with nothing in flight)
        do_reset();
        for (int i = 0; i < 8; i++) begin
            f_m_tvalid = 1'b1;
            f_m_tdata  = tbl[i].tdata;
            tick();
            chk("tbl_valid", 64'(out_valid), 64'h1);
            chk("tbl_ch", 64'(out_ch), 64'(tbl[i].ch));
            chk("tbl_data", 64'(out_data), 64'(tbl[i].data));
            chk("tbl_frame_done", 64'(frame_done), 64'(tbl[i].fd));
        end
        f_m_tvalid = 1'b0;
        tick();
        chk("tbl_idle_valid", 64'({out_valid, frame_done}), 64'h0);
        chk("tbl_seq_err", 64'(seq_err), 64'h1);

        // Randomized traffic against the model
        do_reset();
        ret_mon_en = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            ch_valid   = NCH'($urandom);
            ch_data    = {$urandom, $urandom};
            f_s_tready = ($urandom_range(0, 3) != 0);
            if (model_infl > 0 && $urandom_range(0, 2) != 0) drive_ret({$urandom, $urandom});
            else f_m_tvalid = 1'b0;
            tick();
        end
        ch_valid   = '0;
        f_s_tready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (model_infl > 0) drive_ret({$urandom, $urandom});
            else f_m_tvalid = 1'b0;
            tick();
        end
        f_m_tvalid = 1'b0;
        tick(); tick();
        chk("rand_results_owed", 64'(expq.size()), 64'd0);
        chk("rand_seq_err", 64'(seq_err), 64'h0);
        chk("rand_traffic", 64'(hs_cnt > 100), 64'h1);
        ret_mon_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
